// File: rtl/m_dbus_ctrl_if.sv
// Memory-side request/response bus of the data-bus controller.
// One request in flight; response is a single-cycle valid pulse.
interface m_dbus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rsp_err;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err
    );
endinterface

// File: rtl/m_dbus_ctrl.sv
// Data-bus controller: turns held LSU load/store/flush requests
// into one outstanding valid/ready memory transaction with an ack.
module m_dbus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu2dbus_ld_req,
    input  logic                lsu2dbus_st_req,
    input  logic [ADDR_W-1:0]   dbus_addr,
    input  logic [DATA_W/8-1:0] lsu2dbus_byte_enable,
    input  logic [DATA_W-1:0]   lsu2dbus_W_data,
    input  logic                dcache_flush,
    input  logic                lsu_flush,
    output logic                dbus_ack,
    output logic [DATA_W-1:0]   dbus_rdata,
    output logic                dbus_err,
    m_dbus_ctrl_if.master       mem
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN,
        ACK
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                cap;
    logic                rd_ld;
    logic                err_d;
    logic                err_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    // Next-state and capture strobes; a simultaneous ld/st is a store.
    always_comb begin
        state_n = state;
        cap     = 1'b0;
        rd_ld   = 1'b0;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!lsu_flush) begin
                    if (lsu2dbus_st_req || lsu2dbus_ld_req) begin
                        cap     = 1'b1;
                        state_n = REQ;
                    end else if (dcache_flush) begin
                        state_n = ACK;
                    end
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_n = lsu_flush ? DRAIN : RESP;
                end else if (lsu_flush) begin
                    state_n = IDLE;
                end
            end
            RESP: begin
                if (mem.mem_rsp_valid) begin
                    if (lsu_flush) begin
                        state_n = IDLE;
                    end else begin
                        state_n = ACK;
                        err_d   = mem.mem_rsp_err;
                        rd_ld   = !we_q;
                    end
                end else if (lsu_flush) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (mem.mem_rsp_valid) begin
                    state_n = IDLE;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, request payload, error flag and load data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            err_q <= err_d;
            if (cap) begin
                we_q    <= lsu2dbus_st_req;
                addr_q  <= {dbus_addr[ADDR_W-1:2], 2'b00};
                be_q    <= lsu2dbus_st_req ? lsu2dbus_byte_enable
                                           : {BE_W{1'b1}};
                wdata_q <= lsu2dbus_W_data;
            end
            if (rd_ld) begin
                rdata_q <= mem.mem_rsp_err ? '0 : mem.mem_rdata;
            end
        end
    end

    // Protocol checks on the LSU and memory sides.
    always_ff @(posedge clk) begin
        if (rst_n && state == IDLE && !lsu_flush) begin
            assert (!(lsu2dbus_ld_req && lsu2dbus_st_req));
        end
        if (rst_n) begin
            assert (!mem.mem_rsp_valid || state == RESP || state == DRAIN);
        end
    end

    assign mem.mem_req_valid = (state == REQ);
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_be        = be_q;
    assign mem.mem_wdata     = wdata_q;
    assign dbus_ack          = (state == ACK);
    assign dbus_err          = err_q;
    assign dbus_rdata        = rdata_q;
endmodule

// File: tb/tb_m_dbus_ctrl.sv
// Bench for m_dbus_ctrl: directed plan cases plus random
// transactions against a transaction-level reference.
module tb_m_dbus_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld, st, dflush, lflush;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic        ack, err;
    logic [31:0] rdata;
    logic [31:0] rdata_m;
    int          compared = 0;
    int          mism = 0;

    m_dbus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    m_dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lsu2dbus_ld_req      (ld),
        .lsu2dbus_st_req      (st),
        .dbus_addr            (addr),
        .lsu2dbus_byte_enable (be),
        .lsu2dbus_W_data      (wd),
        .dcache_flush         (dflush),
        .lsu_flush            (lflush),
        .dbus_ack             (ack),
        .dbus_rdata           (rdata),
        .dbus_err             (err),
        .mem                  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with rw ready-wait and dw response-wait cycles.
    task automatic txn(input bit s, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] w,
                       input logic [31:0] r, input bit e,
                       input int rw, input int dw);
        ld = !s;
        st = s;
        addr = a;
        be = b;
        wd = w;
        step();
        for (int i = 0; i <= rw; i++) begin
            chk("req_valid", bus.mem_req_valid, 1);
            chk("req_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
            chk("req_be", bus.mem_be, s ? b : 4'hF);
            chk("req_we", bus.mem_we, s);
            if (s) chk("req_wdata", bus.mem_wdata, w);
            chk("req_noack", ack, 0);
            bus.mem_req_ready = (i == rw);
            step();
        end
        bus.mem_req_ready = 1'b0;
        for (int j = 0; j <= dw; j++) begin
            chk("resp_valid_low", bus.mem_req_valid, 0);
            chk("resp_noack", ack, 0);
            bus.mem_rsp_valid = (j == dw);
            bus.mem_rdata = r;
            bus.mem_rsp_err = e;
            step();
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_err = 1'b0;
        if (!s) rdata_m = e ? 32'h0 : r;
        chk("ack", ack, 1);
        chk("ack_err", err, e);
        chk("ack_rdata", rdata, rdata_m);
        chk("ack_valid_low", bus.mem_req_valid, 0);
        step();
        ld = 1'b0;
        st = 1'b0;
        chk("ack_one_cycle", ack, 0);
        chk("no_reissue", bus.mem_req_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ld = 0; st = 0; dflush = 0; lflush = 0;
        addr = 0; wd = 0; be = 0;
        bus.mem_req_ready = 0;
        bus.mem_rsp_valid = 0;
        bus.mem_rdata = 0;
        bus.mem_rsp_err = 0;
        rdata_m = 32'h0;
        step();
        step();
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_valid", bus.mem_req_valid, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        step();

        txn(0, 32'h8000_0006, 4'b1100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        txn(1, 32'h0000_1000, 4'b0011, 32'h1234_5678, 32'h5555_5555,
            0, 4, 0);

        // Kill while the request waits for ready.
        ld = 1; addr = 32'h0000_2008; be = 4'hF;
        step();
        chk("kreq_valid", bus.mem_req_valid, 1);
        lflush = 1;
        step();
        lflush = 0;
        ld = 0;
        chk("kreq_drop", bus.mem_req_valid, 0);
        chk("kreq_noack", ack, 0);
        step();
        chk("kreq_noack2", ack, 0);
        txn(0, 32'h0000_2008, 4'hF, 32'h0, 32'h0BAD_F00D, 0, 1, 1);

        // Kill after handshake; late response must be swallowed.
        ld = 1; addr = 32'h0000_3000; be = 4'hF;
        step();
        bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready = 0;
        lflush = 1;
        chk("kresp_valid", bus.mem_req_valid, 0);
        step();
        lflush = 0;
        ld = 0;
        chk("kresp_noack", ack, 0);
        step();
        chk("kdrain_valid", bus.mem_req_valid, 0);
        step();
        bus.mem_rsp_valid = 1;
        bus.mem_rdata = 32'hAAAA_AAAA;
        step();
        bus.mem_rsp_valid = 0;
        chk("kdrain_noack", ack, 0);
        chk("kdrain_rdata", rdata, rdata_m);
        step();
        chk("kdrain_noack2", ack, 0);
        txn(1, 32'h0000_3004, 4'b1000, 32'hCAFE_0001, 32'h0, 0, 0, 2);

        txn(0, 32'h0000_4000, 4'hF, 32'h0, 32'hFFFF_FFFF, 1, 0, 0);

        // Cache flush alone acknowledges after one cycle.
        dflush = 1;
        step();
        chk("dfl_ack", ack, 1);
        chk("dfl_err", err, 0);
        chk("dfl_valid", bus.mem_req_valid, 0);
        step();
        dflush = 0;
        chk("dfl_ack_one", ack, 0);
        chk("dfl_noreq", bus.mem_req_valid, 0);

        for (int k = 0; k < 40; k++) begin
            txn($urandom_range(0, 1), $urandom, 4'($urandom), $urandom,
                $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 4),
                $urandom_range(0, 4));
        end

        // Reset arriving while the response is awaited.
        txn(0, 32'h0000_5000, 4'hF, 32'h0, 32'h1357_9BDF, 0, 0, 0);
        st = 1; addr = 32'h0000_6002; be = 4'b0110; wd = 32'h2468_ACE0;
        step();
        bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready = 0;
        rst_n = 0;
        #1;
        rdata_m = 32'h0;
        chk("arst_ack", ack, 0);
        chk("arst_err", err, 0);
        chk("arst_rdata", rdata, rdata_m);
        chk("arst_valid", bus.mem_req_valid, 0);
        chk("arst_we", bus.mem_we, 0);
        chk("arst_addr", bus.mem_addr, 0);
        chk("arst_be", bus.mem_be, 0);
        chk("arst_wdata", bus.mem_wdata, 0);
        st = 0;
        step();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_noack", ack, 0);
            chk("post_rst_valid", bus.mem_req_valid, 0);
        end
        txn(0, 32'h0000_7001, 4'h1, 32'h0, 32'h7777_0000, 0, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end
endmodule
